// File: rtl/sc_speed_tick_generator.sv
// Speed tick generator: drives the up speed counter's upcount/clear controls
// and turns its running count into a one-cycle game tick. The tick period
// comes from a 4-level speed table; the level steps up on falling edges of
// levelUp and saturates at 3.
module sc_speed_tick_generator #(
  parameter int                   DATAWIDTH = 23,
  parameter logic [DATAWIDTH-1:0] LIMIT_L0  = 23'd4999999,
  parameter logic [DATAWIDTH-1:0] LIMIT_L1  = 23'd3749999,
  parameter logic [DATAWIDTH-1:0] LIMIT_L2  = 23'd2499999,
  parameter logic [DATAWIDTH-1:0] LIMIT_L3  = 23'd1249999
) (
  input  logic                 SC_speedTICK_CLOCK_50,
  input  logic                 SC_speedTICK_RESET_InLow,
  input  logic [DATAWIDTH-1:0] SC_speedTICK_count_InBUS,
  input  logic                 SC_speedTICK_pause_InLow,
  input  logic                 SC_speedTICK_levelUp_InLow,
  output logic                 SC_speedTICK_upcount_OutLow,
  output logic                 SC_speedTICK_clear_OutLow,
  output logic                 SC_speedTICK_tick_OutHigh,
  output logic [1:0]           SC_speedTICK_level_OutBUS
);

  typedef enum logic [1:0] {IDLE, COUNT, TICK, PAUSE} state_t;

  state_t               state;
  logic [1:0]           level;
  logic                 levelUpPrev;
  logic                 levelReq;
  logic [DATAWIDTH-1:0] limit;
  logic                 limitHit;

  // Threshold for the current level; the level register feeds the compare
  // directly, so a level change is seen by the compare one cycle later.
  always_comb begin
    limit = LIMIT_L0;
    case (level)
      2'd0: limit = LIMIT_L0;
      2'd1: limit = LIMIT_L1;
      2'd2: limit = LIMIT_L2;
      2'd3: limit = LIMIT_L3;
      default: limit = LIMIT_L0;
    endcase
  end

  // >= rather than == so a limit lowered below the current count still ticks.
  assign limitHit = (SC_speedTICK_count_InBUS >= limit);
  assign levelReq = levelUpPrev & ~SC_speedTICK_levelUp_InLow;
  assign SC_speedTICK_level_OutBUS = level;

  // Level register: one step per levelUp falling edge, saturating at 3.
  always_ff @(posedge SC_speedTICK_CLOCK_50 or negedge SC_speedTICK_RESET_InLow) begin
    if (!SC_speedTICK_RESET_InLow) begin
      levelUpPrev <= 1'b1;
      level       <= 2'd0;
    end else begin
      levelUpPrev <= SC_speedTICK_levelUp_InLow;
      if (levelReq && (level != 2'd3))
        level <= level + 2'd1;
    end
  end

  // Control FSM; outputs are registered together with the state so they
  // always equal the decode of the state being entered.
  always_ff @(posedge SC_speedTICK_CLOCK_50 or negedge SC_speedTICK_RESET_InLow) begin
    if (!SC_speedTICK_RESET_InLow) begin
      state                       <= IDLE;
      SC_speedTICK_upcount_OutLow <= 1'b1;
      SC_speedTICK_clear_OutLow   <= 1'b0;
      SC_speedTICK_tick_OutHigh   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SC_speedTICK_pause_InLow) begin
            state                       <= COUNT;
            SC_speedTICK_upcount_OutLow <= 1'b0;
            SC_speedTICK_clear_OutLow   <= 1'b1;
            SC_speedTICK_tick_OutHigh   <= 1'b0;
          end
        end
        COUNT: begin
          // Pause wins over the compare.
          if (!SC_speedTICK_pause_InLow) begin
            state                       <= PAUSE;
            SC_speedTICK_upcount_OutLow <= 1'b1;
            SC_speedTICK_clear_OutLow   <= 1'b1;
            SC_speedTICK_tick_OutHigh   <= 1'b0;
          end else if (limitHit) begin
            state                       <= TICK;
            SC_speedTICK_upcount_OutLow <= 1'b1;
            SC_speedTICK_clear_OutLow   <= 1'b0;
            SC_speedTICK_tick_OutHigh   <= 1'b1;
          end
        end
        TICK: begin
          // Always exactly one cycle, pause or not.
          state                       <= COUNT;
          SC_speedTICK_upcount_OutLow <= 1'b0;
          SC_speedTICK_clear_OutLow   <= 1'b1;
          SC_speedTICK_tick_OutHigh   <= 1'b0;
        end
        PAUSE: begin
          // Resume without clearing; the counter kept its value.
          if (SC_speedTICK_pause_InLow) begin
            state                       <= COUNT;
            SC_speedTICK_upcount_OutLow <= 1'b0;
            SC_speedTICK_clear_OutLow   <= 1'b1;
            SC_speedTICK_tick_OutHigh   <= 1'b0;
          end
        end
        default: begin
          state                       <= IDLE;
          SC_speedTICK_upcount_OutLow <= 1'b1;
          SC_speedTICK_clear_OutLow   <= 1'b0;
          SC_speedTICK_tick_OutHigh   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_speed_tick_generator.sv
// Bench for sc_speed_tick_generator attached to a behavioural up speed counter,
// with small limits (4,3,2,1) so tick periods are a handful of clocks.
module tb_sc_speed_tick_generator;

  localparam int DW = 23;
  localparam int M_IDLE = 0, M_COUNT = 1, M_TICK = 2, M_PAUSE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pause;
  logic          lvlUp;
  logic [DW-1:0] cnt = '0;
  logic          upcount, clear, tick;
  logic [1:0]    level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_speed_tick_generator #(
    .DATAWIDTH(DW),
    .LIMIT_L0(23'd4), .LIMIT_L1(23'd3), .LIMIT_L2(23'd2), .LIMIT_L3(23'd1)
  ) dut (
    .SC_speedTICK_CLOCK_50      (clk),
    .SC_speedTICK_RESET_InLow   (rst_n),
    .SC_speedTICK_count_InBUS   (cnt),
    .SC_speedTICK_pause_InLow   (pause),
    .SC_speedTICK_levelUp_InLow (lvlUp),
    .SC_speedTICK_upcount_OutLow(upcount),
    .SC_speedTICK_clear_OutLow  (clear),
    .SC_speedTICK_tick_OutHigh  (tick),
    .SC_speedTICK_level_OutBUS  (level)
  );

  // Speed counter: synchronous clear has priority over upcount.
  always @(posedge clk) begin
    if (!clear)        cnt <= '0;
    else if (!upcount) cnt <= cnt + 1'b1;
  end

  function automatic int limit_of(input int lv);
    case (lv)
      0: return 4;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: mode, level, counter value and last levelUp sample, advanced
  // once per clock from the rules (counter + controller as one system).
  int m_mode, m_level, m_cnt, m_next;
  bit m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_level = 0; m_prev = 1'b1; m_cnt = 0;
    end else begin
      m_next = m_mode;
      case (m_mode)
        M_IDLE:  if (pause) m_next = M_COUNT;
        M_COUNT: if (!pause) m_next = M_PAUSE;
                 else if (m_cnt >= limit_of(m_level)) m_next = M_TICK;
        M_TICK:  m_next = M_COUNT;
        default: if (pause) m_next = M_COUNT;
      endcase
      if (m_mode == M_COUNT)      m_cnt = m_cnt + 1;
      else if (m_mode != M_PAUSE) m_cnt = 0;
      if (m_prev && !lvlUp && m_level < 3) m_level = m_level + 1;
      m_prev = lvlUp;
      m_mode = m_next;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_tick",    int'(tick),    int'(m_mode == M_TICK));
    chk("m_upcount", int'(upcount), int'(m_mode != M_COUNT));
    chk("m_clear",   int'(clear),   int'(!(m_mode == M_IDLE || m_mode == M_TICK)));
    chk("m_level",   int'(level),   m_level);
    if (rst_n) chk("m_count", int'(cnt), m_cnt);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
  endtask

  // Cycles until the next tick sample (1 = tick on the very next cycle).
  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin cyc(); n++; end while (!tick && n < maxc);
    if (!tick) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no tick within %0d cycles at %0t", maxc, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pause = 1'b1; lvlUp = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic pulse_level();
    lvlUp = 1'b0; cyc();
    lvlUp = 1'b1; cyc();
  endtask

  typedef struct {
    logic pause;
    logic lvlUp;
    logic tick;
    int   cnt;
    int   level;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Cycles after reset release with pause=1: count 0..5 then wrap, tick at 5.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 3, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 5, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 3, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 5, 0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 0, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1, 0};

    rst_n = 1'b0; pause = 1'b0; lvlUp = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_upcount", int'(upcount), 1);
    chk("rst_clear", int'(clear), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_count", int'(cnt), 0);

    // Release; one IDLE cycle before COUNT.
    rst_n = 1'b1;
    #1;
    chk("idle_upcount", int'(upcount), 1);
    chk("idle_clear", int'(clear), 0);
    for (int i = 0; i < 14; i++) begin
      pause = tbl[i].pause; lvlUp = tbl[i].lvlUp;
      cyc();
      chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].tick));
      chk($sformatf("tbl%0d_count", i), int'(cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].level);
    end

    // Period per level, stepping the level between measurements.
    for (int lv = 0; lv < 4; lv++) begin
      wait_tick(20, n);
      wait_tick(20, n);
      chk($sformatf("period_l%0d", lv), n, limit_of(lv) + 2);
      if (lv < 3) begin
        pulse_level();
        chk($sformatf("level_step%0d", lv + 1), int'(level), lv + 1);
      end
    end

    // Saturation: a fourth edge and a long low hold leave level at 3.
    pulse_level();
    chk("sat_edge", int'(level), 3);
    lvlUp = 1'b0;
    repeat (20) cyc();
    chk("sat_hold", int'(level), 3);
    lvlUp = 1'b1; cyc();
    wait_tick(20, n);
    wait_tick(20, n);
    chk("sat_period", n, 3);

    // Pause at count 2: count holds at 3, tick two COUNT cycles after release.
    do_reset();
    cyc(); cyc(); cyc();
    chk("pz_count2", int'(cnt), 2);
    pause = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("pz_hold_count", int'(cnt), 3);
      chk("pz_hold_tick", int'(tick), 0);
      chk("pz_upcount", int'(upcount), 1);
      chk("pz_clear", int'(clear), 1);
    end
    pause = 1'b1;
    cyc(); chk("pz_rel1_tick", int'(tick), 0); chk("pz_rel1_count", int'(cnt), 3);
    cyc(); chk("pz_rel2_tick", int'(tick), 0); chk("pz_rel2_count", int'(cnt), 4);
    cyc(); chk("pz_rel3_tick", int'(tick), 1);

    // Level 0 -> 3 while count sits at 3: compare true right away, one tick.
    do_reset();
    cyc(); cyc(); cyc();
    pause = 1'b0; cyc();
    chk("lv3_count", int'(cnt), 3);
    pulse_level(); pulse_level(); pulse_level();
    chk("lv3_level", int'(level), 3);
    chk("lv3_count_kept", int'(cnt), 3);
    pause = 1'b1;
    cyc(); chk("lv3_a_tick", int'(tick), 0);
    cyc(); chk("lv3_b_tick", int'(tick), 1);
    cyc(); chk("lv3_c_tick", int'(tick), 0);
    cyc(); chk("lv3_d_tick", int'(tick), 0);
    cyc(); chk("lv3_e_tick", int'(tick), 1);

    // Reset pulsed during TICK: outputs drop at once, restart from IDLE.
    wait_tick(20, n);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_clear", int'(clear), 0);
    cyc();
    rst_n = 1'b1;
    #1 chk("mid_rst_count", int'(cnt), 0);
    wait_tick(20, n);
    chk("mid_rst_first_tick", n, 6);

    // Random traffic against the reference, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) begin
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
      end
      pause = ($urandom_range(0, 9) != 0);
      lvlUp = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
